// File: rtl/clk_seq_pkg.sv
// clk_seq_pkg: shared definitions for the clock/reset sequencer.
//   - domain indices (core, mem, noc) and the invalid domain code
//   - power-up order (mem first, then noc, then core)
//   - sequencer state encoding and runtime request op encoding
//   - dom_mask(): maps a domain index to a one-hot 3-bit mask (0 for invalid)
package clk_seq_pkg;

   localparam int         NUM_DOM     = 3;
   localparam logic [1:0] DOM_CORE    = 2'd0;
   localparam logic [1:0] DOM_MEM     = 2'd1;
   localparam logic [1:0] DOM_NOC     = 2'd2;
   localparam logic [1:0] DOM_INVALID = 2'd3;

   // PWR_ORDER[0] is brought up first.
   localparam logic [2:0][1:0] PWR_ORDER = {DOM_CORE, DOM_NOC, DOM_MEM};

   typedef enum logic {
      OP_DISABLE = 1'b0,
      OP_ENABLE  = 1'b1
   } req_op_e;

   typedef enum logic [3:0] {
      ST_PLL_WAIT,
      ST_HOLD,
      ST_EN_CLK,
      ST_DONE,
      ST_RUN,
      ST_ON_CLK,
      ST_ON_HOLD,
      ST_OFF_RST,
      ST_OFF_HOLD,
      ST_ACK,
      ST_RESP
   } state_e;

   function automatic logic [2:0] dom_mask(input logic [1:0] dom);
      logic [2:0] mask;
      case (dom)
         DOM_CORE: mask = 3'b001;
         DOM_MEM:  mask = 3'b010;
         DOM_NOC:  mask = 3'b100;
         default:  mask = 3'b000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/clk_seq_timer.sv
// clk_seq_timer: loadable down-counter shared by all sequencer wait states.
// Counts down to zero and holds there; expired is high while the count is 0.
// A wait of N cycles is obtained by loading N-1 on state entry.
//   ext_clk      in   sequencer clock
//   ext_reset_n  in   async active-low reset (count returns to RST_VAL)
//   load         in   load load_val on the next edge
//   load_val     in   CW-bit reload value
//   expired      out  count is zero
module clk_seq_timer
   import clk_seq_pkg::*;
#(
   parameter int             CW      = 5,
   parameter logic [CW-1:0]  RST_VAL = '0
) (
   input  logic          ext_clk,
   input  logic          ext_reset_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          expired
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge ext_clk or negedge ext_reset_n) begin
      if (!ext_reset_n)
         cnt_q <= RST_VAL;
      else
         cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/clk_rst_sequencer.sv
// clk_rst_sequencer: power-up and runtime clock/reset sequencer for the
// core, mem and noc clock domains.
// Power-up: wait LOCK_CYCLES, then per domain (mem, noc, core) raise clk_en,
// hold HOLD_CYCLES with reset asserted, release dom_rst_n, one gap cycle.
// Runtime: enable/disable requests on a valid/ready handshake, answered with
// a one-cycle resp_valid pulse (resp_err marks a rejected request).
// Optional build macro CLK_SEQ_DEP_CHECK_EN: reject requests that would break
// the mem <- noc <- core dependency chain.
//   ext_clk      in   sequencer clock
//   ext_reset_n  in   async active-low reset
//   req_valid    in   runtime request valid
//   req_ready    out  high only while idle in RUN
//   req_domain   in   0 core, 1 mem, 2 noc, 3 invalid
//   req_op       in   1 enable, 0 disable
//   resp_valid   out  one-cycle completion pulse
//   resp_err     out  request rejected (qualified by resp_valid)
//   clk_en       out  per-domain clock enable
//   dom_rst_n    out  per-domain reset, active-low
//   seq_done     out  power-up finished, sticky until reset
//
// state       | meaning
// PLL_WAIT    | waiting LOCK_CYCLES after reset; expiry raises first clk_en
// HOLD        | domain clock running, reset held; expiry releases reset
// EN_CLK      | gap cycle; raises the next domain's clk_en
// DONE        | all domains up; raises seq_done and req_ready
// RUN         | idle, accepting requests
// ON_CLK      | enable accepted; raises clk_en of the target
// ON_HOLD     | enable hold; expiry releases reset and responds
// OFF_RST     | disable accepted; asserts reset of the target
// OFF_HOLD    | disable hold; expiry stops clock and responds
// ACK         | no-op or rejected request; responds next edge
// RESP        | response cycle; returns to RUN
module clk_rst_sequencer
   import clk_seq_pkg::*;
#(
   parameter int LOCK_CYCLES = 16,
   parameter int HOLD_CYCLES = 4
) (
   input  logic       ext_clk,
   input  logic       ext_reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_domain,
   input  logic       req_op,
   output logic       resp_valid,
   output logic       resp_err,
   output logic [2:0] clk_en,
   output logic [2:0] dom_rst_n,
   output logic       seq_done
);

   localparam int            MAX_LH  = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
   localparam int            CW      = $clog2(MAX_LH) + 1;
   localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [1:0] dom_q, dom_d;
   logic       ack_err_q, ack_err_d;
   logic [2:0] clk_en_q, clk_en_d;
   logic [2:0] dom_rst_n_q, dom_rst_n_d;
   logic       seq_done_q, seq_done_d;
   logic       req_ready_q, req_ready_d;
   logic       resp_valid_q, resp_valid_d;
   logic       resp_err_q, resp_err_d;

   logic       tmr_load;
   logic       tmr_exp;
   logic       dep_ok;
   logic       is_on;
   logic [1:0] nxt_idx;

   clk_seq_timer #(
      .CW      (CW),
      .RST_VAL (LOCK_LD)
   ) u_timer (
      .ext_clk     (ext_clk),
      .ext_reset_n (ext_reset_n),
      .load        (tmr_load),
      .load_val    (HOLD_LD),
      .expired     (tmr_exp)
   );

   // Dependency check on the incoming request, judged against current clocks.
   always_comb begin
      dep_ok = 1'b1;
`ifdef CLK_SEQ_DEP_CHECK_EN
      if (req_op == OP_ENABLE) begin
         case (req_domain)
            DOM_NOC:  dep_ok = clk_en_q[DOM_MEM];
            DOM_CORE: dep_ok = clk_en_q[DOM_NOC];
            default:  dep_ok = 1'b1;
         endcase
      end else begin
         case (req_domain)
            DOM_MEM: dep_ok = !clk_en_q[DOM_NOC] && !clk_en_q[DOM_CORE];
            DOM_NOC: dep_ok = !clk_en_q[DOM_CORE];
            default: dep_ok = 1'b1;
         endcase
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dom_d        = dom_q;
      ack_err_d    = ack_err_q;
      clk_en_d     = clk_en_q;
      dom_rst_n_d  = dom_rst_n_q;
      seq_done_d   = seq_done_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      tmr_load     = 1'b0;
      nxt_idx      = idx_q + 2'd1;
      is_on        = (clk_en_q & dom_mask(req_domain)) != 3'b000;

      case (state_q)
         ST_PLL_WAIT: begin
            if (tmr_exp) begin
               clk_en_d = clk_en_q | dom_mask(PWR_ORDER[0]);
               tmr_load = 1'b1;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_exp) begin
               dom_rst_n_d = dom_rst_n_q | dom_mask(PWR_ORDER[idx_q]);
               state_d     = (idx_q == 2'(NUM_DOM - 1)) ? ST_DONE : ST_EN_CLK;
            end
         end
         ST_EN_CLK: begin
            idx_d    = nxt_idx;
            clk_en_d = clk_en_q | dom_mask(PWR_ORDER[nxt_idx]);
            tmr_load = 1'b1;
            state_d  = ST_HOLD;
         end
         ST_DONE: begin
            seq_done_d  = 1'b1;
            req_ready_d = 1'b1;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               dom_d       = req_domain;
               ack_err_d   = 1'b0;
               if (req_domain == DOM_INVALID) begin
                  ack_err_d = 1'b1;
                  state_d   = ST_ACK;
               end else if (is_on == (req_op == OP_ENABLE)) begin
                  state_d = ST_ACK;
               end else if (!dep_ok) begin
                  ack_err_d = 1'b1;
                  state_d   = ST_ACK;
               end else begin
                  state_d = (req_op == OP_ENABLE) ? ST_ON_CLK : ST_OFF_RST;
               end
            end
         end
         ST_ON_CLK: begin
            clk_en_d = clk_en_q | dom_mask(dom_q);
            tmr_load = 1'b1;
            state_d  = ST_ON_HOLD;
         end
         ST_ON_HOLD: begin
            if (tmr_exp) begin
               dom_rst_n_d  = dom_rst_n_q | dom_mask(dom_q);
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end
         end
         ST_OFF_RST: begin
            dom_rst_n_d = dom_rst_n_q & ~dom_mask(dom_q);
            tmr_load    = 1'b1;
            state_d     = ST_OFF_HOLD;
         end
         ST_OFF_HOLD: begin
            if (tmr_exp) begin
               clk_en_d     = clk_en_q & ~dom_mask(dom_q);
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end
         end
         ST_ACK: begin
            resp_valid_d = 1'b1;
            resp_err_d   = ack_err_q;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            req_ready_d = 1'b1;
            state_d     = ST_RUN;
         end
         default: state_d = ST_PLL_WAIT;
      endcase
   end

   always_ff @(posedge ext_clk or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
         state_q      <= ST_PLL_WAIT;
         idx_q        <= 2'd0;
         dom_q        <= 2'd0;
         ack_err_q    <= 1'b0;
         clk_en_q     <= 3'b000;
         dom_rst_n_q  <= 3'b000;
         seq_done_q   <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         dom_q        <= dom_d;
         ack_err_q    <= ack_err_d;
         clk_en_q     <= clk_en_d;
         dom_rst_n_q  <= dom_rst_n_d;
         seq_done_q   <= seq_done_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign clk_en     = clk_en_q;
   assign dom_rst_n  = dom_rst_n_q;
   assign seq_done   = seq_done_q;
   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb_clk_rst_sequencer: power-up timing, runtime requests and mid-sequence
// reset for clk_rst_sequencer. Expected responses go into a queue when a
// request is accepted; a monitor pops them whenever resp_valid is seen.
module tb_clk_rst_sequencer;

   localparam int L = 16;
   localparam int H = 4;
   localparam logic [1:0] D_CORE = 2'd0;
   localparam logic [1:0] D_MEM  = 2'd1;
   localparam logic [1:0] D_NOC  = 2'd2;
`ifdef CLK_SEQ_DEP_CHECK_EN
   localparam bit DEP_CHECK = 1'b1;
`else
   localparam bit DEP_CHECK = 1'b0;
`endif

   logic       ext_clk = 1'b0;
   logic       ext_reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_domain = 2'd0;
   logic       req_op = 1'b0;
   logic       req_ready, resp_valid, resp_err, seq_done;
   logic [2:0] clk_en, dom_rst_n;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      int         due;
      logic       err;
      logic [2:0] on;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] on_m = 3'b000;

   clk_rst_sequencer #(.LOCK_CYCLES(L), .HOLD_CYCLES(H)) dut (
      .ext_clk     (ext_clk),
      .ext_reset_n (ext_reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_domain  (req_domain),
      .req_op      (req_op),
      .resp_valid  (resp_valid),
      .resp_err    (resp_err),
      .clk_en      (clk_en),
      .dom_rst_n   (dom_rst_n),
      .seq_done    (seq_done)
   );

   always #5 ext_clk = ~ext_clk;

   // Cycle n = n-th rising edge with reset released.
   always @(posedge ext_clk or negedge ext_reset_n) begin
      if (!ext_reset_n) cyc <= 0;
      else              cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every resp_valid must match the oldest outstanding expectation.
   always @(negedge ext_clk) begin : mon
      exp_t e;
      if (ext_reset_n && resp_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp at cycle %0d: got resp_valid=1 expected no response", cyc);
         end else begin
            e = sb.pop_front();
            check("resp_cycle", cyc, e.due);
            check("resp_err", resp_err, e.err);
            check("resp_clk_en", clk_en, e.on);
            check("resp_dom_rst_n", dom_rst_n, e.on);
            check("resp_ready_low", req_ready, 0);
         end
      end
   end

   // Compare outputs against the documented power-up edge schedule.
   task automatic check_powerup(input int last);
      logic [2:0] ce, rn;
      for (int n = 1; n <= last; n++) begin
         @(negedge ext_clk);
         ce[D_MEM]  = (n >= L);
         rn[D_MEM]  = (n >= L + H);
         ce[D_NOC]  = (n >= L + H + 1);
         rn[D_NOC]  = (n >= L + 2*H + 1);
         ce[D_CORE] = (n >= L + 2*H + 2);
         rn[D_CORE] = (n >= L + 3*H + 2);
         check("pu_cycle", cyc, n);
         check("pu_clk_en", clk_en, ce);
         check("pu_dom_rst_n", dom_rst_n, rn);
         check("pu_seq_done", seq_done, (n >= L + 3*H + 3));
         check("pu_req_ready", req_ready, (n >= L + 3*H + 3));
      end
   endtask

   // Issue one request at a negedge; returns the acceptance cycle.
   task automatic do_req(input logic [1:0] d, input logic op, output int acc);
      int   budget;
      logic exec;
      logic viol;
      exp_t e;
      acc = -1;
      req_valid  = 1'b1;
      req_domain = d;
      req_op     = op;
      budget = 0;
      while (!req_ready && budget < 200) begin
         @(negedge ext_clk);
         budget++;
      end
      if (!req_ready) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout: got req_ready=0 after %0d cycles expected 1", budget);
         req_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      // Reference model: decide outcome from the request rules alone.
      exec  = 1'b0;
      e.due = acc + 1;
      e.err = 1'b0;
      if (op)
         viol = (d == D_NOC && !on_m[D_MEM]) || (d == D_CORE && !on_m[D_NOC]);
      else
         viol = (d == D_MEM && (on_m[D_NOC] || on_m[D_CORE])) || (d == D_NOC && on_m[D_CORE]);
      if (d == 2'd3)
         e.err = 1'b1;
      else if (on_m[d] == op)
         e.err = 1'b0;
      else if (DEP_CHECK && viol)
         e.err = 1'b1;
      else begin
         exec    = 1'b1;
         e.due   = acc + 1 + H;
         on_m[d] = op;
      end
      e.on = on_m;
      sb.push_back(e);

      @(negedge ext_clk);
      req_valid  = 1'b0;
      req_domain = 2'($urandom);
      req_op     = 1'($urandom);
      check("accept_ready_drop", req_ready, 0);
      if (exec) begin
         @(negedge ext_clk);
         check("mid_clk_en", clk_en[d], 1);
         check("mid_dom_rst_n", dom_rst_n[d], 0);
      end
      budget = 0;
      while ((sb.size() != 0 || !req_ready) && budget < 50) begin
         @(negedge ext_clk);
         budget++;
      end
      if (sb.size() != 0 || !req_ready) begin
         tests++;
         fails++;
         $display("FAIL resp_timeout: got %0d pending responses ready=%0b expected 0 pending ready=1", sb.size(), req_ready);
         sb.delete();
      end
   endtask

   initial begin
      int a;
      // req_valid held high through power-up: must not be accepted early.
      ext_reset_n = 1'b0;
      req_valid   = 1'b1;
      req_domain  = D_CORE;
      req_op      = 1'b0;
      repeat (3) @(negedge ext_clk);
      check("reset_outputs", {clk_en, dom_rst_n, seq_done, req_ready, resp_valid, resp_err}, 0);
      ext_reset_n = 1'b1;
      check_powerup(L + 3*H + 3);
      on_m = 3'b111;

      do_req(D_CORE, 1'b0, a);
      check("first_accept_cycle", a, L + 3*H + 4);
      do_req(D_CORE, 1'b1, a);
      do_req(2'd3, 1'b1, a);
      do_req(2'd3, 1'b0, a);
      do_req(D_NOC, 1'b1, a);
      do_req(D_MEM, 1'b0, a);
      do_req(D_MEM, 1'b1, a);

      repeat (40) begin
         repeat ($urandom_range(0, 3)) @(negedge ext_clk);
         do_req(2'($urandom), 1'($urandom), a);
      end

      // Reset while noc is in its hold window, then a clean power-up.
      @(negedge ext_clk);
      ext_reset_n = 1'b0;
      repeat (2) @(negedge ext_clk);
      ext_reset_n = 1'b1;
      on_m = 3'b000;
      check_powerup(22);
      ext_reset_n = 1'b0;
      #1;
      check("midseq_reset_outputs", {clk_en, dom_rst_n, seq_done, req_ready, resp_valid, resp_err}, 0);
      repeat (3) @(negedge ext_clk);
      ext_reset_n = 1'b1;
      check_powerup(L + 3*H + 3);
      on_m = 3'b111;

      do_req(D_NOC, 1'b1, a);
      do_req(D_CORE, 1'b0, a);
      do_req(D_NOC, 1'b0, a);
      do_req(D_NOC, 1'b1, a);

      repeat (3) @(negedge ext_clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by time %0t expected completion", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
